req_gnt_responder: RTL and testbench
====================================

# req_gnt_responder

Grant-side responder for the req/gnt handshake whose requirement is that `gnt` follows `req` within 1..5 clocks. It arbitrates up to N_REQ requesters round-robin and issues a one-cycle grant pulse after a programmable latency. A per-requester watchdog flags any request left ungranted beyond MAX_LAT cycles. It sits opposite the requesting initiators.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- MAX_LAT, 5: latency bound in cycles; also the clamp for `lat_cfg`.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  level requests; a requester holds `req` until it samples its `gnt`, then drops it.
- lat_cfg  in  3  grant latency L in cycles; 0 means 1; values above MAX_LAT clamp to MAX_LAT; sampled when a winner is selected.
- err_clr  in  1  clears `lat_err`.
- gnt  out  N_REQ  one-hot grant, high for exactly one cycle.
- gnt_id  out  $clog2(N_REQ)  index of the current or last winner.
- busy  out  1  high in WAIT or GRANT.
- lat_err  out  N_REQ  sticky per-requester latency violation.

## Operation
- FSM states: IDLE, WAIT, GRANT. Reset values: state IDLE, rr pointer 0, `gnt` 0, `gnt_id` 0, `busy` 0, `lat_err` 0, all age counters 0.
- **IDLE**, when `|req` is high at an edge:
  - Pick the winner as the first set `req` bit at or after the rr pointer, wrapping.
  - Latch the winner into `gnt_id`.
  - Latch the effective L.
  - If L==1, go to GRANT. Otherwise go to WAIT with cnt=L-1.
- **WAIT**: cnt decrements each edge.
  - At the edge where cnt==1, go to GRANT if `req[gnt_id]` is still high.
  - If `req[gnt_id]` is low, go to IDLE with no grant. This is an abort; the pointer is unchanged.
- **GRANT**: `gnt[gnt_id]` is high for this one cycle and is driven from registered state only. At the exit edge:
  - The pointer becomes gnt_id+1, modulo N_REQ.
  - Pending requests are `req` with the bit `gnt_id` masked off.
  - If any are pending, re-arbitrate immediately using the IDLE rules. With L==1 this gives back-to-back grants to different requesters.
  - If none are pending, go to IDLE.
- **Watchdog**, per requester i:
  - age[i] increments on each edge where `req[i]` is high and `gnt[i]` is low. It saturates at MAX_LAT+1.
  - age[i] clears when `req[i]` is low or `gnt[i]` is high.
  - `lat_err[i]` sets when age[i] reaches MAX_LAT+1, i.e. no grant was sampled by edge t+MAX_LAT.
  - `err_clr` clears all `lat_err` bits. If clear and a new set occur at the same edge, the set wins.
- Width rules:
  - cnt and age are $clog2(MAX_LAT+2) bits.
  - The `lat_cfg` clamp is computed at full 3-bit width before truncation.

## Timing
- Latency: `req` is first sampled high at edge t while IDLE. `gnt` is then sampled high at edge t+L, for L in 1..MAX_LAT.
- A lone requester is always granted within MAX_LAT and never sets `lat_err`.
- Contention: each further requester waits L cycles after the previous grant, so with L=1 the worst case is N_REQ cycles.
- `busy` and `gnt_id` are valid from the edge the winner is selected.
- `req` dropping in the same cycle as its `gnt` is legal and expected.
- A requester whose `req` is still high after GRANT is not re-granted until the rr rotation returns to it.
- Reset during WAIT or GRANT: at the reset edge `gnt` is 0, all state returns to reset values, and the pending grant is lost.

## Structure
- Package `req_gnt_pkg`:
  - state enum {IDLE, WAIT, GRANT};
  - MAX_LAT_DEFAULT=5;
  - lat_clamp function.
- Sub-module `rr_arbiter`: combinational rotate-priority pick. Inputs are the request vector and pointer; outputs are the winner index and a valid flag. Instantiated once.
- The top level holds the FSM, cnt, the pointer, and the age/`lat_err` array.

## Test plan
- After reset, req=4'b0001 with lat_cfg=2 -> gnt=4'b0001 sampled at t+2, only that cycle; gnt_id=0; lat_err=0.
- lat_cfg=0 -> grant at t+1. lat_cfg=7 -> grant at t+5. Neither sets lat_err.
- req=4'b1111 at t with lat_cfg=1 -> grants 0,1,2,3 at t+1..t+4, each requester dropping req on its grant; lat_err=0. Same stimulus with lat_cfg=2 -> grants at t+2, t+4, t+6, t+8; lat_err=4'b1100.
- req[1] high, lat_cfg=4, req[1] dropped at t+2 -> no gnt, FSM back in IDLE, busy=0 by t+4.
- rst_n low at t+2 during WAIT -> gnt, gnt_id, busy and lat_err all 0. Next req=4'b0110 grants requester 1 first, since the pointer is reset to 0.
- Force lat_err[3]=1, then pulse err_clr with no new violation -> lat_err=0. Pulse err_clr on the same edge as a new violation on requester 2 -> lat_err[2]=1.

Source files
------------

// File: rtl/req_gnt_responder_pkg.sv
// req_gnt_pkg: shared types and helpers for the req/gnt responder.
//   state_t         - responder FSM states
//   MAX_LAT_DEFAULT - default latency bound in cycles
//   lat_clamp()     - maps the raw 3-bit latency setting to an effective L
package req_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int MAX_LAT_DEFAULT = 5;

    // Effective latency: 0 behaves as 1, anything above max_lat is pulled
    // down to max_lat. Evaluated at the full 3-bit width of the setting.
    function automatic logic [2:0] lat_clamp(input logic [2:0] cfg,
                                             input logic [2:0] max_lat);
        logic [2:0] eff;
        if (cfg == 3'd0) begin
            eff = 3'd1;
        end else if (cfg > max_lat) begin
            eff = max_lat;
        end else begin
            eff = cfg;
        end
        return eff;
    endfunction

endpackage

// File: rtl/req_gnt_responder_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick.
//   req   in  N_REQ  request vector
//   ptr   in  IW     highest-priority index for this pick
//   idx   out IW     first set request at or after ptr, wrapping
//   valid out 1      at least one request is set
module rr_arbiter
    import req_gnt_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // cand[k] is the requester index examined at priority position k.
    logic [IW-1:0] cand [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum = {1'b0, ptr} + (IW+1)'(gi);
            // ptr < N_REQ, so a single subtraction is enough to wrap.
            assign cand[gi] = (sum >= (IW+1)'(N_REQ)) ?
                              IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
        end
    endgenerate

    // Scan from lowest to highest priority so the last hit (position 0
    // side) wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx   = cand[k];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_gnt_responder.sv
// req_gnt_responder: grant-side responder for a req/gnt handshake.
// Arbitrates round-robin, issues a one-cycle grant L cycles after the
// winner is picked, and flags requests left waiting beyond MAX_LAT.
//   clk      in  1      clock
//   rst_n    in  1      synchronous active-low reset
//   req      in  N_REQ  level requests
//   lat_cfg  in  3      grant latency setting (clamped to 1..MAX_LAT)
//   err_clr  in  1      clears lat_err (a same-edge new violation wins)
//   gnt      out N_REQ  one-hot, one-cycle grant
//   gnt_id   out IW     current or last winner
//   busy     out 1      high while a grant is pending or issued
//   lat_err  out N_REQ  sticky per-requester latency violation
module req_gnt_responder
    import req_gnt_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LAT = MAX_LAT_DEFAULT,
    localparam int IW = $clog2(N_REQ),
    localparam int CW = $clog2(MAX_LAT + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       lat_cfg,
    input  logic             err_clr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_id,
    output logic             busy,
    output logic [N_REQ-1:0] lat_err
);

    localparam logic [CW-1:0] AGE_LAST = CW'(MAX_LAT);
    localparam logic [CW-1:0] AGE_SAT  = CW'(MAX_LAT + 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [IW-1:0]    gnt_id_reg, gnt_id_next;

    logic [IW-1:0]    ptr_inc;
    logic [IW-1:0]    arb_ptr;
    logic [IW-1:0]    arb_idx;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] gnt_mask;
    logic             arb_valid;
    logic             launch;
    logic [CW-1:0]    lat_eff;

    assign ptr_inc  = (gnt_id_reg == IW'(N_REQ - 1)) ? '0 : gnt_id_reg + IW'(1);
    assign gnt_mask = N_REQ'(1) << gnt_id_reg;
    assign lat_eff  = CW'(lat_clamp(lat_cfg, 3'(MAX_LAT)));

    // On the GRANT exit edge the arbiter already sees the advanced pointer
    // and the just-granted requester masked off, so back-to-back grants go
    // to a different requester.
    assign arb_ptr = (state_reg == GRANT) ? ptr_inc : ptr_reg;
    assign arb_req = (state_reg == GRANT) ? (req & ~gnt_mask) : req;
    assign launch  = arb_valid && ((state_reg == IDLE) || (state_reg == GRANT));

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (arb_req),
        .ptr   (arb_ptr),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            ptr_reg    <= '0;
            gnt_id_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ptr_reg    <= ptr_next;
            gnt_id_reg <= gnt_id_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ptr_next    = ptr_reg;
        gnt_id_next = gnt_id_reg;

        case (state_reg)
            IDLE: begin
            end
            WAIT: begin
                cnt_next = cnt_reg - CW'(1);
                // Winner withdrew before its grant: abort, pointer untouched.
                if (cnt_reg == CW'(1)) begin
                    state_next = req[gnt_id_reg] ? GRANT : IDLE;
                end
            end
            GRANT: begin
                ptr_next   = ptr_inc;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (launch) begin
            gnt_id_next = arb_idx;
            if (lat_eff == CW'(1)) begin
                state_next = GRANT;
                cnt_next   = '0;
            end else begin
                state_next = WAIT;
                cnt_next   = lat_eff - CW'(1);
            end
        end
    end

    // Outputs come from registered state only.
    always_comb begin
        gnt  = '0;
        busy = 1'b0;
        if (state_reg == GRANT) begin
            gnt = gnt_mask;
        end
        if (state_reg != IDLE) begin
            busy = 1'b1;
        end
    end

    assign gnt_id = gnt_id_reg;

    // Per-requester watchdog. The error fires on the edge the age counter
    // steps from MAX_LAT to its saturation value.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wd
            logic [CW-1:0] age_reg, age_next;
            logic          lat_err_reg;
            logic          waiting;
            logic          err_set;

            assign waiting = req[gi] & ~gnt[gi];
            assign err_set = waiting && (age_reg == AGE_LAST);

            always_comb begin
                age_next = '0;
                if (waiting) begin
                    age_next = (age_reg == AGE_SAT) ? age_reg : age_reg + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    age_reg     <= '0;
                    lat_err_reg <= 1'b0;
                end else begin
                    age_reg <= age_next;
                    if (err_set) begin
                        lat_err_reg <= 1'b1;
                    end else if (err_clr) begin
                        lat_err_reg <= 1'b0;
                    end
                end
            end

            assign lat_err[gi] = lat_err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_req_gnt_responder.sv
// Testbench for req_gnt_responder: latency table, directed multi-cycle
// sequences, then randomized traffic against a timestamp-based model.
module tb_req_gnt_responder;

    localparam int NR = 4;
    localparam int ML = 5;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] req     = '0;
    logic [2:0] lat_cfg = '0;
    logic       err_clr = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [3:0] lat_err;

    int errors = 0;
    int checks = 0;

    req_gnt_responder #(
        .N_REQ   (NR),
        .MAX_LAT (ML)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .lat_cfg (lat_cfg),
        .err_clr (err_clr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .lat_err (lat_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Burst: raise pattern r, each requester drops req after the edge that
    // samples its grant. Records grant times (edges after t) and ids.
    int b_times[8];
    int b_ids[8];
    int b_ng;

    task automatic burst(input logic [3:0] r, input logic [2:0] cfg, input int clr_at);
        logic [3:0] drop;
        drop    = '0;
        b_ng    = 0;
        req     = r;
        lat_cfg = cfg;
        for (int k = 0; k < 40 && (req != 4'b0 || drop != 4'b0); k++) begin
            err_clr = (k == clr_at);
            @(posedge clk);
            #1;
            req  = req & ~drop;
            drop = '0;
            if (gnt != 4'b0) begin
                if (b_ng < 8) begin
                    b_times[b_ng] = k + 1;
                    b_ids[b_ng]   = onehot_idx(gnt);
                end
                b_ng++;
                drop = gnt;
            end
        end
        err_clr = 1'b0;
        $display("burst req=%b cfg=%0d grants=%0d lat_err=%b", r, cfg, b_ng, lat_err);
    endtask

    task automatic check_burst(input string name, input int n, input int t[4], input int id[4]);
        check({name, "_count"}, b_ng, n);
        for (int i = 0; i < n && i < b_ng; i++) begin
            check($sformatf("%s_time%0d", name, i), b_times[i], t[i]);
            check($sformatf("%s_id%0d", name, i), b_ids[i], id[i]);
        end
    endtask

    // Reference model: tracks the chosen winner and the absolute edge at
    // which its grant is sampled, plus per-requester wait start edges.
    int         e_cnt;
    bit         m_busy;
    int         m_win;
    int         m_gedge;
    int         m_ptr;
    logic [3:0] m_err;
    logic [3:0] m_gnow;
    bit         m_wait[4];
    int         m_start[4];

    task automatic m_reset();
        e_cnt   = 0;
        m_busy  = 1'b0;
        m_win   = 0;
        m_gedge = 0;
        m_ptr   = 0;
        m_err   = '0;
        m_gnow  = '0;
        for (int i = 0; i < NR; i++) begin
            m_wait[i]  = 1'b0;
            m_start[i] = 0;
        end
    endtask

    task automatic m_edge(input logic [3:0] r, input logic [2:0] cfg, input logic clr);
        int         lat;
        logic [3:0] set;
        logic [3:0] pend;
        bit         found;
        lat    = (cfg == 3'd0) ? 1 : ((int'(cfg) > ML) ? ML : int'(cfg));
        m_gnow = (m_busy && m_gedge == e_cnt) ? (4'b0001 << m_win) : 4'b0000;
        set    = '0;
        for (int i = 0; i < NR; i++) begin
            if (r[i] && !m_gnow[i]) begin
                if (!m_wait[i]) begin
                    m_wait[i]  = 1'b1;
                    m_start[i] = e_cnt;
                end
                if (e_cnt - m_start[i] == ML) set[i] = 1'b1;
            end else begin
                m_wait[i] = 1'b0;
            end
        end
        m_err = set | (clr ? 4'b0000 : m_err);
        if (m_gnow != 4'b0) begin
            m_ptr  = (m_win + 1) % NR;
            pend   = r & ~m_gnow;
            m_busy = 1'b0;
        end else begin
            pend = m_busy ? 4'b0000 : r;
        end
        if (pend != 4'b0) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!found && pend[(m_ptr + k) % NR]) begin
                    m_win = (m_ptr + k) % NR;
                    found = 1'b1;
                end
            end
            m_gedge = e_cnt + lat;
            m_busy  = 1'b1;
        end
    endtask

    typedef struct {
        logic [3:0] r;
        logic [2:0] cfg;
        int         delay;
        int         id;
    } lat_vec_t;

    lat_vec_t tbl[8];

    initial begin
        logic [3:0] seen;
        logic [3:0] exp_gnt;

        tbl[0] = '{4'b0001, 3'd2, 2, 0};
        tbl[1] = '{4'b0001, 3'd0, 1, 0};
        tbl[2] = '{4'b0001, 3'd7, 5, 0};
        tbl[3] = '{4'b0010, 3'd1, 1, 1};
        tbl[4] = '{4'b0100, 3'd3, 3, 2};
        tbl[5] = '{4'b0010, 3'd6, 5, 1};
        tbl[6] = '{4'b0100, 3'd5, 5, 2};
        tbl[7] = '{4'b1000, 3'd4, 4, 3};

        // Reset state
        rst_n = 1'b0;
        step(); step(); step();
        check("rst_gnt", gnt, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_busy", busy, 0);
        check("rst_lat_err", lat_err, 0);
        $display("reset: gnt=%b gnt_id=%0d busy=%b lat_err=%b", gnt, gnt_id, busy, lat_err);
        rst_n = 1'b1;
        step();

        // Single-requester latency table
        foreach (tbl[i]) begin
            burst(tbl[i].r, tbl[i].cfg, -1);
            check($sformatf("tbl%0d_count", i), b_ng, 1);
            check($sformatf("tbl%0d_delay", i), b_times[0], tbl[i].delay);
            check($sformatf("tbl%0d_id", i), b_ids[0], tbl[i].id);
            check($sformatf("tbl%0d_gnt_after", i), gnt, 0);
            check($sformatf("tbl%0d_busy_after", i), busy, 0);
            check($sformatf("tbl%0d_lat_err", i), lat_err, 0);
        end

        // All four at L=1: back-to-back grants
        burst(4'b1111, 3'd1, -1);
        check_burst("all_l1", 4, '{1, 2, 3, 4}, '{0, 1, 2, 3});
        check("all_l1_lat_err", lat_err, 4'b0000);

        // All four at L=2: the last two exceed the bound
        burst(4'b1111, 3'd2, -1);
        check_burst("all_l2", 4, '{2, 4, 6, 8}, '{0, 1, 2, 3});
        check("all_l2_lat_err", lat_err, 4'b1100);

        // Move the pointer to 2, then reset in the middle of a WAIT
        burst(4'b0010, 3'd1, -1);
        check_burst("ptr_to2", 1, '{1, 0, 0, 0}, '{1, 0, 0, 0});
        req = 4'b0100;
        lat_cfg = 3'd5;
        step();
        check("wait_busy", busy, 1);
        check("wait_gnt_id", gnt_id, 2);
        step();
        rst_n = 1'b0;
        req = 4'b0000;
        step();
        check("midrst_gnt", gnt, 0);
        check("midrst_gnt_id", gnt_id, 0);
        check("midrst_busy", busy, 0);
        check("midrst_lat_err", lat_err, 0);
        $display("reset during wait: gnt=%b gnt_id=%0d busy=%b lat_err=%b", gnt, gnt_id, busy, lat_err);
        rst_n = 1'b1;
        step();
        burst(4'b0110, 3'd1, -1);
        check_burst("after_rst", 2, '{1, 2, 0, 0}, '{1, 2, 0, 0});

        // Abort: requester 1 withdraws during WAIT; pointer stays at 3
        seen = '0;
        req = 4'b0010;
        lat_cfg = 3'd4;
        step();
        seen |= gnt;
        check("abort_busy_start", busy, 1);
        step();
        seen |= gnt;
        req = 4'b0000;
        step();
        seen |= gnt;
        step();
        seen |= gnt;
        check("abort_no_gnt", seen, 0);
        check("abort_busy_end", busy, 0);
        $display("abort: seen_gnt=%b busy=%b", seen, busy);
        burst(4'b1100, 3'd1, -1);
        check_burst("abort_ptr", 2, '{1, 2, 0, 0}, '{3, 2, 0, 0});

        // Violation on requester 3, then clear it
        burst(4'b1000, 3'd1, -1);
        burst(4'b1001, 3'd5, -1);
        check_burst("viol3", 2, '{5, 10, 0, 0}, '{0, 3, 0, 0});
        check("viol3_lat_err", lat_err, 4'b1000);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_lat_err", lat_err, 4'b0000);
        $display("err_clr: lat_err=%b", lat_err);

        // err_clr on the same edge as a new violation on requester 2
        burst(4'b0101, 3'd5, 5);
        check_burst("clr_vs_set", 2, '{5, 10, 0, 0}, '{0, 2, 0, 0});
        check("clr_vs_set_lat_err", lat_err, 4'b0100);

        // Randomized traffic against the model
        rst_n = 1'b0;
        req = '0;
        err_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_reset();
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            e_cnt++;
            m_edge(req, lat_cfg, err_clr);
            #1;
            exp_gnt = (m_busy && m_gedge == e_cnt + 1) ? (4'b0001 << m_win) : 4'b0000;
            check("rnd_gnt", gnt, exp_gnt);
            check("rnd_busy", busy, m_busy);
            check("rnd_gnt_id", gnt_id, m_win);
            check("rnd_lat_err", lat_err, m_err);
            if (m_gnow != 4'b0) begin
                $display("rnd edge %0d: grant %b lat_err=%b", e_cnt, m_gnow, lat_err);
            end
            for (int i = 0; i < NR; i++) begin
                if (m_gnow[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            lat_cfg = 3'($urandom_range(7));
            err_clr = ($urandom_range(15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
